dma_xfer_ctrl: RTL and testbench

Single-channel DMA transfer engine that copies a block of bytes from one memory address range to another over the shared 8-bit data bus. It sits directly upstream of `memory`: it drives `Address`, `MemRead` and `Enable`, answers the memory's `DB_wrReq` with `DB_tri`, captures read data from `DB_io`, and drives `DB_io` for writes. On the other side it arbitrates for the bus with the CPU through a request/grant pair.

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_addr_ctr.sv | 25 ++
 rtl/dma_xfer_ctrl.sv | 156 +++++++++++++++
 tb/tb_dma_xfer_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and defaults for the single-channel DMA transfer engine.
package dma_pkg;
  localparam int AW_DEF         = 8;
  localparam int DW_DEF         = 8;
  localparam int RD_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE,
    ST_ERR
  } state_t;
endpackage

// File: rtl/dma_addr_ctr.sv
// Loadable wrapping address incrementer; exposes the value it will hold after
// the next edge so the caller can register outputs without a cycle of lag.
module dma_addr_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q_nxt
);
  logic [W-1:0] q;

  always_comb begin
    q_nxt = q;
    if (load)     q_nxt = load_val;
    else if (inc) q_nxt = q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_nxt;
  end
endmodule

// File: rtl/dma_xfer_ctrl.sv
// Single-channel memory-to-memory byte copier with HOLD/HLDA bus arbitration.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | bus requested, waiting for grant
// RD    | read strobe on src, waiting for DB_wrReq (timeout armed)
// CAP   | memory drives DB_io, data latched on exit
// WR    | latched byte driven to dst, pointers advance on exit
// DONE  | one-cycle done pulse, bus released
// ERR   | read timeout, error set, bus released
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [7:0]    count,
  output logic          bus_req,
  input  logic          bus_grant,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] Address,
  output logic          MemRead,
  output logic          Enable,
  input  logic          DB_wrReq,
  output logic          DB_tri,
  inout  wire  [DW-1:0] DB_io
);
  state_t        state, state_nxt;
  logic          accept, in_wr;
  logic [AW-1:0] src_nxt, dst_nxt;
  logic [7:0]    remaining, tmr;
  logic [DW-1:0] data_q;
  logic          wr_drive;
  logic          rd_phase;
  logic          bus_req_d, busy_d, done_d, error_d, enable_d, memread_d, tri_d, drive_d;
  logic [AW-1:0] address_d;

  assign accept = (state == ST_IDLE) && start && (count != 8'd0);
  assign in_wr  = (state == ST_WR);

  dma_addr_ctr #(.W(AW)) u_src_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (src_addr),
    .inc      (in_wr),
    .q_nxt    (src_nxt)
  );

  dma_addr_ctr #(.W(AW)) u_dst_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (dst_addr),
    .inc      (in_wr),
    .q_nxt    (dst_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_REQ;
      ST_REQ:  if (bus_grant) state_nxt = ST_RD;
      ST_RD: begin
        if (DB_wrReq)          state_nxt = ST_CAP;
        else if (tmr == 8'd1)  state_nxt = ST_ERR;
      end
      ST_CAP:  state_nxt = ST_WR;
      ST_WR: begin
        // Grant is only re-checked here, so a byte in flight always completes.
        if (remaining == 8'd1) state_nxt = ST_DONE;
        else if (bus_grant)    state_nxt = ST_RD;
        else                   state_nxt = ST_REQ;
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_comb begin
    rd_phase  = (state_nxt == ST_RD) || (state_nxt == ST_CAP);
    bus_req_d = rd_phase || (state_nxt == ST_REQ) || (state_nxt == ST_WR);
    busy_d    = (state_nxt != ST_IDLE);
    done_d    = (state_nxt == ST_DONE) ||
                ((state == ST_IDLE) && start && (count == 8'd0));
    error_d   = error;
    if (state_nxt == ST_ERR) error_d = 1'b1;
    else if (accept)         error_d = 1'b0;
    enable_d  = rd_phase || (state_nxt == ST_WR);
    memread_d = rd_phase;
    tri_d     = (state_nxt == ST_CAP);
    drive_d   = (state_nxt == ST_WR);
    address_d = '0;
    if (rd_phase)                 address_d = src_nxt;
    else if (state_nxt == ST_WR)  address_d = dst_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      Enable   <= 1'b0;
      MemRead  <= 1'b0;
      DB_tri   <= 1'b0;
      wr_drive <= 1'b0;
      Address  <= '0;
    end else begin
      bus_req  <= bus_req_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
      Enable   <= enable_d;
      MemRead  <= memread_d;
      DB_tri   <= tri_d;
      wr_drive <= drive_d;
      Address  <= address_d;
    end
  end

  // Read-timeout down-counter, armed on every entry into RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       tmr <= 8'd0;
    else if ((state_nxt == ST_RD) && (state != ST_RD)) tmr <= 8'(RD_TIMEOUT);
    else if (state == ST_RD)                          tmr <= tmr - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      remaining <= 8'd0;
    else if (accept) remaining <= count;
    else if (in_wr)  remaining <= remaining - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               data_q <= '0;
    else if (state == ST_CAP) data_q <= DB_io;
  end

  assign DB_io = wr_drive ? data_q : {DW{1'bz}};
endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl with a behavioural byte memory on the bus.
// Cycle index k counts negedges after the start edge; k=1 is the first REQ cycle.
module tb_dma_xfer_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, start, bus_grant, no_req;
  logic [7:0] src_addr, dst_addr, count;
  logic       bus_req, busy, done, error, MemRead, Enable, DB_tri, DB_wrReq;
  logic [7:0] Address;
  wire  [7:0] DB_io;
  logic [7:0] mem [0:255];
  logic       pl_we;
  logic [7:0] pl_addr, pl_data;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt, done_at;
  logic       any_act;

  always #5 clk = ~clk;

  dma_xfer_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .count     (count),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .Address   (Address),
    .MemRead   (MemRead),
    .Enable    (Enable),
    .DB_wrReq  (DB_wrReq),
    .DB_tri    (DB_tri),
    .DB_io     (DB_io)
  );

  // Undriven bus reads back as all ones.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (DB_io[i]);
  end

  assign DB_wrReq = Enable && MemRead && !no_req;
  assign DB_io    = (DB_tri && Enable && MemRead) ? mem[Address] : 8'hzz;

  always @(posedge clk) begin
    if (pl_we)                           mem[pl_addr] <= pl_data;
    else if (rst_n && Enable && !MemRead) mem[Address] <= DB_io;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(DB_tri && Enable && !MemRead) &&
              (DB_tri || (Enable && !MemRead) || (DB_io === 8'hff))) else begin
        errors++;
        $error("FAIL bus_drive: observed tri=%b en=%b rd=%b io=%h expected no overlap and idle bus",
               DB_tri, Enable, MemRead, DB_io);
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    src_addr = s; dst_addr = d; count = n; start = 1'b1;
    done_cnt = 0; done_at = 0; any_act = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bus_grant = 1'b1; no_req = 1'b0;
    src_addr = 8'd0; dst_addr = 8'd0; count = 8'd0;
    pl_we = 1'b0; pl_addr = 8'd0; pl_data = 8'd0;
    #2;
    chk("rst_address", Address, 0);
    chk("rst_enable", Enable, 0);
    chk("rst_busreq", bus_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dbio", DB_io, 8'hff);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Normal copy
    poke(8'd10, 8'hA1); poke(8'd11, 8'hB2); poke(8'd12, 8'hC3); poke(8'd13, 8'hD4);
    launch(8'd10, 8'd40, 8'd4);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin done_cnt++; done_at = k; end
      if (k == 1) begin chk("n_busreq_lat", bus_req, 1); chk("n_busy", busy, 1); end
      if (k == 2) begin chk("n_rd_addr", Address, 8'h0a); chk("n_rd_memread", MemRead, 1); chk("n_rd_en", Enable, 1); end
      if (k == 3) chk("n_cap_tri", DB_tri, 1);
      if (k == 4) begin chk("n_wr_addr", Address, 8'h28); chk("n_wr_memread", MemRead, 0); chk("n_wr_data", DB_io, 8'hA1); end
    end
    chk("n_done_cnt", done_cnt, 1);
    chk("n_done_at", done_at, 14);
    chk("n_error", error, 0);
    chk("n_mem40", mem[40], 8'hA1);
    chk("n_mem41", mem[41], 8'hB2);
    chk("n_mem42", mem[42], 8'hC3);
    chk("n_mem43", mem[43], 8'hD4);

    // Address wrap (dst overlaps src, so byte 3 re-reads the freshly written mem[0])
    poke(8'd254, 8'h11); poke(8'd255, 8'h22); poke(8'd0, 8'h33);
    launch(8'd254, 8'd0, 8'd3);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin done_cnt++; done_at = k; end
      if (k == 5) chk("w_addr_ff", Address, 8'hff);
      if (k == 8) begin chk("w_addr_wrap", Address, 8'h00); chk("w_memread", MemRead, 1); end
    end
    chk("w_done_cnt", done_cnt, 1);
    chk("w_done_at", done_at, 11);
    chk("w_mem0", mem[0], 8'h11);
    chk("w_mem1", mem[1], 8'h22);
    chk("w_mem2", mem[2], 8'h11);

    // Zero count
    launch(8'd10, 8'd50, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin done_cnt++; done_at = k; end
      any_act = any_act | bus_req | Enable | MemRead | busy;
    end
    chk("z_done_at", done_at, 1);
    chk("z_done_cnt", done_cnt, 1);
    chk("z_no_bus", any_act, 0);

    // Grant loss during byte 2
    poke(8'd60, 8'h5A); poke(8'd61, 8'h6B); poke(8'd62, 8'h7C); poke(8'd63, 8'h8D);
    launch(8'd60, 8'd70, 8'd4);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin done_cnt++; done_at = k; end
      if (k == 5) chk("g_rd2_addr", Address, 8'h3d);
      if (k == 6) chk("g_cap_kept", DB_tri, 1);
      if (k == 7) begin chk("g_wr2_addr", Address, 8'h47); chk("g_wr2_data", DB_io, 8'h6B); end
      if (k == 8) begin chk("g_req_en", Enable, 0); chk("g_req_busreq", bus_req, 1); end
      if (k == 10) chk("g_wait_en", Enable, 0);
      if (k == 11) begin chk("g_rd3_addr", Address, 8'h3e); chk("g_rd3_memread", MemRead, 1); end
      if (k == 5)  bus_grant = 1'b0;
      if (k == 10) bus_grant = 1'b1;
    end
    chk("g_done_cnt", done_cnt, 1);
    chk("g_done_at", done_at, 17);
    chk("g_mem70", mem[70], 8'h5A);
    chk("g_mem71", mem[71], 8'h6B);
    chk("g_mem72", mem[72], 8'h7C);
    chk("g_mem73", mem[73], 8'h8D);

    // Read timeout, then recovery
    no_req = 1'b1;
    launch(8'd5, 8'd6, 8'd2);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin done_cnt++; done_at = k; end
      if (k == 16) begin chk("t_last_rd_en", Enable, 1); chk("t_err_pre", error, 0); end
      if (k == 17) begin chk("t_err_set", error, 1); chk("t_busreq_off", bus_req, 0); end
      if (k == 18) begin chk("t_err_sticky", error, 1); chk("t_idle", busy, 0); end
    end
    chk("t_no_done", done_cnt, 0);
    no_req = 1'b0;
    launch(8'd10, 8'd90, 8'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin done_cnt++; done_at = k; end
      if (k == 1) chk("t_err_clear", error, 0);
    end
    chk("t_rec_done_at", done_at, 5);
    chk("t_rec_mem90", mem[90], 8'hA1);

    // Asynchronous reset in CAP
    launch(8'd10, 8'd100, 8'd2);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    chk("r_in_cap", DB_tri, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_address", Address, 0);
    chk("r_memread", MemRead, 0);
    chk("r_enable", Enable, 0);
    chk("r_tri", DB_tri, 0);
    chk("r_dbio", DB_io, 8'hff);
    chk("r_busreq", bus_req, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    any_act = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      any_act = any_act | bus_req | busy | done;
    end
    chk("r_stays_idle", any_act, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
